bicubic_win_fetch: RTL

//  Upstream stage of the Bicubic interpolation engine.
//  For each requested source point (integer part IX,IY, relative to the ROI) it reads the 4x4 neighbourhood

---
 rtl/bicubic_win_fetch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bicubic_win_fetch.sv
// 4x4 neighbourhood fetch for the bicubic interpolator: reads clamped taps from ImgROM,
// reuses three columns when the next request is the horizontal neighbour.
module bicubic_win_fetch #(
  parameter int IMG_W = 100,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [6:0]       H0,
  input  logic [6:0]       V0,
  input  logic [4:0]       SW,
  input  logic [4:0]       SH,
  input  logic             FLUSH,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [4:0]       REQ_X,
  input  logic [4:0]       REQ_Y,
  output logic             ROM_RD,
  output logic [AW-1:0]    ROM_A,
  input  logic [DW-1:0]    ROM_Q,
  output logic             WIN_VALID,
  input  logic             WIN_READY,
  output logic [16*DW-1:0] WIN_DATA,
  output logic             BUSY
);

  typedef enum logic [2:0] {IDLE, FULL, SHIFT, DRAIN, HOLD} state_t;

  state_t        state_reg;
  logic [4:0]    ix_reg;
  logic [4:0]    iy_reg;
  logic          reuse_reg;
  logic [3:0]    cnt_reg;
  logic [3:0]    slot_reg;
  logic [3:0]    cap_slot_reg;
  logic          cap_vld_reg;
  logic [DW-1:0] win_reg [16];

  logic          take_shift;
  logic          last_issue;
  logic [3:0]    next_cnt;
  logic [3:0]    next_slot;
  logic [AW-1:0] next_addr;

  // Tap position base+off-1, clamped into [0, size-1].
  function automatic logic [4:0] clamp_tap(input logic [4:0] base, input logic [1:0] off,
                                           input logic [4:0] size);
    logic signed [6:0] t;
    t = $signed({2'b00, base}) + $signed({5'b00000, off}) - 7'sd1;
    if (t < 7'sd0)
      return 5'd0;
    if (t > $signed({2'b00, size}) - 7'sd1)
      return size - 5'd1;
    return t[4:0];
  endfunction

  // Slot numbering is r*4+c, so slot[3:2] selects the row tap and slot[1:0] the column tap.
  function automatic logic [AW-1:0] tap_addr(input logic [4:0] ix, input logic [4:0] iy,
                                             input logic [3:0] slot);
    logic [4:0]    tx;
    logic [4:0]    ty;
    logic [AW-1:0] row;
    tx  = clamp_tap(ix, slot[1:0], SW);
    ty  = clamp_tap(iy, slot[3:2], SH);
    row = AW'(V0) + AW'(ty);
    return row * AW'(IMG_W) + AW'(H0) + AW'(tx);
  endfunction

  always_comb begin
    take_shift = reuse_reg && !FLUSH && (REQ_Y == iy_reg) &&
                 ({1'b0, REQ_X} == {1'b0, ix_reg} + 6'd1);
    last_issue = (state_reg == FULL) ? (cnt_reg == 4'd15) : (cnt_reg == 4'd3);
    next_cnt   = cnt_reg + 4'd1;
    case (state_reg)
      IDLE:    next_slot = take_shift ? 4'd3 : 4'd0;
      SHIFT:   next_slot = {next_cnt[1:0], 2'b11};
      default: next_slot = next_cnt;
    endcase
    if (state_reg == IDLE)
      next_addr = tap_addr(REQ_X, REQ_Y, next_slot);
    else
      next_addr = tap_addr(ix_reg, iy_reg, next_slot);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      ix_reg       <= '0;
      iy_reg       <= '0;
      reuse_reg    <= 1'b0;
      cnt_reg      <= '0;
      slot_reg     <= '0;
      cap_slot_reg <= '0;
      cap_vld_reg  <= 1'b0;
      ROM_RD       <= 1'b0;
      ROM_A        <= '0;
      for (int i = 0; i < 16; i++)
        win_reg[i] <= '0;
    end else begin
      // Synchronous ROM: data for the slot issued two edges ago is on ROM_Q now.
      cap_vld_reg  <= ROM_RD;
      cap_slot_reg <= slot_reg;
      if (cap_vld_reg)
        win_reg[cap_slot_reg] <= ROM_Q;

      case (state_reg)
        IDLE: begin
          if (REQ_VALID) begin
            ix_reg   <= REQ_X;
            iy_reg   <= REQ_Y;
            cnt_reg  <= '0;
            slot_reg <= next_slot;
            ROM_A    <= next_addr;
            ROM_RD   <= 1'b1;
            if (take_shift) begin
              state_reg <= SHIFT;
              for (int r = 0; r < 4; r++)
                for (int c = 0; c < 3; c++)
                  win_reg[r*4+c] <= win_reg[r*4+c+1];
            end else begin
              state_reg <= FULL;
            end
          end
        end
        FULL, SHIFT: begin
          if (last_issue) begin
            ROM_RD    <= 1'b0;
            state_reg <= DRAIN;
          end else begin
            cnt_reg  <= next_cnt;
            slot_reg <= next_slot;
            ROM_A    <= next_addr;
          end
        end
        DRAIN:   state_reg <= HOLD;
        HOLD:    if (WIN_READY) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (FLUSH)
        reuse_reg <= 1'b0;
      else if (state_reg == HOLD && WIN_READY)
        reuse_reg <= 1'b1;
    end
  end

  assign REQ_READY = (state_reg == IDLE);
  assign BUSY      = (state_reg != IDLE);
  assign WIN_VALID = (state_reg == HOLD);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_win
      assign WIN_DATA[gi*DW +: DW] = win_reg[gi];
    end
  endgenerate

endmodule
